dmem_lsu_ctrl: RTL and testbench

- Load/store controller between the pipeline MEM stage and the word-wide data memory.
- Sequences RV32I byte, halfword and word accesses onto a memory with 32-bit write and registered-address read (1-cycle read latency).
- Sub-word stores use a read-modify-write sequence. Sub-word loads are sign- or zero-extended.
- Misaligned, out-of-range and illegal accesses are flagged as errors and never touch memory.

---
 rtl/dmem_lsu_ctrl_pkg.sv | 69 ++++++
 rtl/dmem_lsu_ctrl_lane_unit.sv | 19 +
 rtl/dmem_lsu_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types and lane helpers for the data-memory load/store controller.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know signed widths; the unsigned encodings are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    r = 32'h0;
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      F3_W:    r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Overlay the low bits of the store data onto the addressed lane.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  funct3);
    logic [31:0] r;
    r = word;
    case (funct3)
      F3_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      F3_W:    r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_lane_unit.sv
// Combinational lane extract/merge datapath used by the controller.
module dmem_lane_unit
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  // Both results are pure functions of the current memory word and latched request.
  always_comb begin
    extracted = lane_extract(load_word, lane, funct3);
    merged    = lane_merge(load_word, store_data, lane, funct3);
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller: sequences RV32I accesses onto a word-wide RAM with
// one-cycle registered read. Sub-word stores are done as read-modify-write.
module dmem_lsu_ctrl #(
  parameter int          WORD_AW   = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_st_data,
  input  logic [31:0] i_mem_load_data
);
  import dmem_lsu_pkg::*;

  lsu_state_e         state_reg;
  logic               we_reg;
  logic [2:0]         f3_reg;
  logic [WORD_AW-1:0] word_reg;
  logic [1:0]         lane_reg;
  logic [31:0]        wdata_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic [31:0]        rsp_rdata_reg;

  logic [31:0]        off;
  logic [WORD_AW-1:0] req_word;
  logic [1:0]         req_lane;
  logic               req_err;
  logic               req_is_half;
  logic               req_is_word;
  logic               accept;
  logic [31:0]        extracted;
  logic [31:0]        merged;

  // Request decode: window offset, word index, lane and fault detection.
  always_comb begin
    off         = i_req_addr - BASE_ADDR;
    req_word    = off[WORD_AW+1:2];
    req_lane    = off[1:0];
    req_is_half = (i_req_funct3 == F3_H) || (i_req_funct3 == F3_HU);
    req_is_word = (i_req_funct3 == F3_W);
    req_err     = (|off[31:WORD_AW+2])
                | ~f3_legal(i_req_we, i_req_funct3)
                | (req_is_half & off[0])
                | (req_is_word & (|off[1:0]));
  end

  assign o_req_ready = (state_reg == ST_IDLE);
  assign accept      = i_req_valid & o_req_ready;

  dmem_lane_unit u_lane (
    .load_word  (i_mem_load_data),
    .store_data (wdata_reg),
    .lane       (lane_reg),
    .funct3     (f3_reg),
    .extracted  (extracted),
    .merged     (merged)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      word_reg      <= '0;
      lane_reg      <= 2'b00;
      wdata_reg     <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'h0;
          if (accept) begin
            we_reg    <= i_req_we;
            f3_reg    <= i_req_funct3;
            word_reg  <= req_word;
            lane_reg  <= req_lane;
            wdata_reg <= i_req_wdata;
            if (req_err) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end else if (i_req_we && req_is_word) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
            end else if (!i_req_we) begin
              state_reg <= ST_LOAD;
            end else begin
              state_reg <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata_reg <= extracted;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_MERGE: begin
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'h0;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Memory port: address is combinational in IDLE so the RAM sees it on the accept edge.
  always_comb begin
    o_mem_addr    = {{(32-WORD_AW){1'b0}}, word_reg};
    o_mem_wren    = 1'b0;
    o_mem_st_data = 32'h0;
    case (state_reg)
      ST_IDLE: begin
        o_mem_addr    = {{(32-WORD_AW){1'b0}}, req_word};
        o_mem_st_data = i_req_wdata;
        if (accept && !req_err && i_req_we && req_is_word) o_mem_wren = 1'b1;
      end
      ST_MERGE: begin
        o_mem_wren    = we_reg;
        o_mem_st_data = merged;
      end
      default: ;
    endcase
    // Reset must kill any write, including the MERGE write already in flight.
    if (i_rst) o_mem_wren = 1'b0;
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_err   = rsp_err_reg;
  assign o_rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl against a byte-addressed reference memory.
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_st_data;
  logic [31:0] mem_load_data;

  int asserts;
  int fails;

  localparam int MEM_BYTES = 8192;

  logic [31:0] ram [0:2047];
  logic [7:0]  byte_mem [0:MEM_BYTES-1];

  dmem_lsu_ctrl #(.WORD_AW(11), .BASE_ADDR(32'h0)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_we        (req_we),
    .i_req_funct3    (req_funct3),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_err       (rsp_err),
    .o_rsp_rdata     (rsp_rdata),
    .o_mem_wren      (mem_wren),
    .o_mem_addr      (mem_addr),
    .o_mem_st_data   (mem_st_data),
    .i_mem_load_data (mem_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM with registered read, as seen by the controller.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[10:0]] <= mem_st_data;
    mem_load_data <= ram[mem_addr[10:0]];
  end

  // ---------------- reference model (byte-level) ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    if (addr >= MEM_BYTES) return 1'b1;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    longint unsigned v;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(byte_mem[addr + i]) << (8 * i));
    if (f3[2] == 1'b0 && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    int a;
    a = addr & ~32'h3;
    return {byte_mem[a+3], byte_mem[a+2], byte_mem[a+1], byte_mem[a]};
  endfunction

  task automatic apply_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < size_of(f3); i++) byte_mem[addr + i] = wdata[8*i +: 8];
  endtask

  // One complete request/response; entered and left at a settled point in IDLE.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got_rdata);
    bit          e_err;
    bit          e_merge;
    bit          e_sw;
    int          e_lat;
    int          lat;
    int          wren_seen;
    bit          got;
    logic [31:0] e_rdata;
    logic [31:0] e_merge_word;

    e_err   = exp_err(we, f3, addr);
    e_sw    = !e_err && we && (f3 == 3'd2);
    e_merge = !e_err && we && (f3 != 3'd2);
    e_lat   = (e_err || e_sw) ? 1 : 2;
    e_rdata = (!e_err && !we) ? exp_load(f3, addr) : 32'h0;

    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    asserts++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_idle: got %b want 1", req_ready); end
    asserts++;
    if (mem_wren !== e_sw) begin fails++; $display("FAIL accept_wren addr=%h: got %b want %b", addr, mem_wren, e_sw); end
    if (!e_err) begin
      asserts++;
      if (mem_addr !== (addr >> 2)) begin fails++; $display("FAIL accept_addr: got %h want %h", mem_addr, addr >> 2); end
    end
    if (e_sw) begin
      asserts++;
      if (mem_st_data !== wdata) begin fails++; $display("FAIL sw_data: got %h want %h", mem_st_data, wdata); end
    end
    if (!e_err && we) apply_store(f3, addr, wdata);
    e_merge_word = word_of(addr);

    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    lat = 1; wren_seen = 0; got = 0;
    while (lat <= 4) begin
      if (mem_wren) begin
        wren_seen++;
        asserts++;
        if (mem_st_data !== e_merge_word || mem_addr !== (addr >> 2)) begin
          fails++;
          $display("FAIL merge_write: got %h@%h want %h@%h", mem_st_data, mem_addr, e_merge_word, addr >> 2);
        end
      end
      if (rsp_valid) begin got = 1; break; end
      @(posedge clk); #2;
      lat++;
    end
    got_rdata = rsp_rdata;
    asserts++;
    if (!got) begin fails++; $display("FAIL rsp_timeout addr=%h: no response", addr); end
    else begin
      asserts++;
      if (lat != e_lat) begin fails++; $display("FAIL latency addr=%h: got %0d want %0d", addr, lat, e_lat); end
      asserts++;
      if (rsp_err !== e_err) begin fails++; $display("FAIL rsp_err addr=%h: got %b want %b", addr, rsp_err, e_err); end
      asserts++;
      if (rsp_rdata !== e_rdata) begin fails++; $display("FAIL rsp_rdata addr=%h: got %h want %h", addr, rsp_rdata, e_rdata); end
    end
    asserts++;
    if (wren_seen != (e_merge ? 1 : 0)) begin fails++; $display("FAIL merge_wren_count: got %0d want %0d", wren_seen, e_merge ? 1 : 0); end
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> err=%b rdata=%h lat=%0d", we, f3, addr, wdata, rsp_err, rsp_rdata, lat);
    @(posedge clk); #2;
    asserts++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL rsp_one_cycle: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h1234_5678;
    repeat (3) begin
      @(posedge clk); #2;
      asserts++;
      if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    asserts++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    asserts++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    $display("txn reset done");
  endtask

  task automatic test_word();
    logic [31:0] r;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, r);
    asserts++;
    if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_const: got %h want deadbeef", r); end
  endtask

  task automatic test_sub_word();
    logic [31:0] r;
    do_req(1'b1, 3'd0, 32'h12, 32'h0000_0055, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, r);
    asserts++;
    if (r !== 32'hDE55BEEF) begin fails++; $display("FAIL sb_merge_const: got %h want de55beef", r); end
    do_req(1'b0, 3'd0, 32'h12, 32'h0, r);
    asserts++;
    if (r !== 32'h0000_0055) begin fails++; $display("FAIL lb12_const: got %h want 00000055", r); end
    do_req(1'b0, 3'd0, 32'h13, 32'h0, r);
    asserts++;
    if (r !== 32'hFFFF_FFDE) begin fails++; $display("FAIL lb13_const: got %h want ffffffde", r); end
    do_req(1'b0, 3'd4, 32'h13, 32'h0, r);
    asserts++;
    if (r !== 32'h0000_00DE) begin fails++; $display("FAIL lbu13_const: got %h want 000000de", r); end
    do_req(1'b1, 3'd2, 32'h14, 32'h1234_5678, r);
    do_req(1'b1, 3'd1, 32'h16, 32'h0000_8001, r);
    do_req(1'b0, 3'd1, 32'h16, 32'h0, r);
    asserts++;
    if (r !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_const: got %h want ffff8001", r); end
    do_req(1'b0, 3'd5, 32'h16, 32'h0, r);
    asserts++;
    if (r !== 32'h0000_8001) begin fails++; $display("FAIL lhu_const: got %h want 00008001", r); end
    do_req(1'b0, 3'd2, 32'h14, 32'h0, r);
    asserts++;
    if (r !== 32'h8001_5678) begin fails++; $display("FAIL sh_low_half_const: got %h want 80015678", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    do_req(1'b0, 3'd2, 32'h11, 32'h0, r);
    do_req(1'b1, 3'd1, 32'h13, 32'h0000_AAAA, r);
    do_req(1'b0, 3'd0, 32'h2000, 32'h0, r);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, r);
    do_req(1'b1, 3'd4, 32'h10, 32'h0000_00FF, r);
    do_req(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1111_1111, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, r);
    asserts++;
    if (r !== 32'hDE55BEEF) begin fails++; $display("FAIL err_no_write: got %h want de55beef", r); end
  endtask

  task automatic test_reset_mid_merge();
    logic [31:0] r;
    bit          seen;
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h0000_00AA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    asserts++;
    if (mem_wren !== 1'b0) begin fails++; $display("FAIL rst_merge_wren: got %b want 0", mem_wren); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    asserts++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_merge_ready: got %b want 1", req_ready); end
    seen = 1'b0;
    repeat (3) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #2;
    end
    asserts++;
    if (seen) begin fails++; $display("FAIL rst_merge_rsp: got response want none"); end
    $display("txn reset during MERGE done");
    do_req(1'b0, 3'd2, 32'h20, 32'h0, r);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;
    for (int n = 0; n < 120; n++) begin
      we = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'h2000 + $urandom_range(0, 255);
      else addr = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      do_req(we, f3, addr, $urandom, r);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          k;
    int          resp;
    int          cyc;
    bit          pending;
    bit          acc_now;
    bit          acc_prev;
    k = 0; resp = 0; pending = 0; acc_prev = 0;
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = $urandom; req_valid = 1'b1;
    #1;
    for (cyc = 0; cyc < 100 && resp < N; cyc++) begin
      acc_now = 0;
      if (rsp_valid) begin
        e = exp_q.pop_front();
        asserts++;
        if (rsp_err !== 1'b0 || rsp_rdata !== e) begin
          fails++; $display("FAIL b2b_rsp %0d: got err=%b rdata=%h want 0/%h", resp, rsp_err, rsp_rdata, e);
        end
        $display("txn b2b rsp %0d rdata=%h", resp, rsp_rdata);
        resp++;
        pending = 0;
      end
      if (acc_prev) begin
        asserts++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_accept: got 1 want 0"); end
      end
      if (req_valid && req_ready) begin
        asserts++;
        if (pending) begin fails++; $display("FAIL b2b_overlap: accept while response pending"); end
        pending = 1; acc_now = 1;
        if (req_we) begin apply_store(3'd2, 32'h40, req_wdata); exp_q.push_back(32'h0); end
        else exp_q.push_back(exp_load(3'd2, 32'h40));
      end
      @(posedge clk); #1;
      if (acc_now) begin
        k++;
        if (k >= N) req_valid = 1'b0;
        req_we = (k % 2 == 0);
        req_wdata = $urandom;
      end
      acc_prev = acc_now;
      #1;
    end
    asserts++;
    if (k != N || resp != N) begin fails++; $display("FAIL b2b_count: accepted=%0d responses=%0d want %0d", k, resp, N); end
    req_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    asserts = 0; fails = 0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) byte_mem[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_sub_word();
    test_errors();
    test_reset_mid_merge();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
